// File: rtl/gclken_gen.sv
// Multi-channel clock-enable generator: per-channel pulse/toggle output, period act+1, registered Z/TC (1 cycle).
// Define GCLKEN_STATUS_EN to expose the per-channel PEND and sticky shadow-overwrite OVF flags.
module gclken_gen #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       MODE,
    input  logic [CHANNELS*WIDTH-1:0] DIV,
    input  logic [CHANNELS-1:0]       LD,
    input  logic                      SYNC,
    output logic [CHANNELS-1:0]       Z,
    output logic [CHANNELS-1:0]       TC
`ifdef GCLKEN_STATUS_EN
    ,
    output logic [CHANNELS-1:0]       PEND,
    output logic [CHANNELS-1:0]       OVF
`endif
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] act_q, act_d;
        logic [WIDTH-1:0] sh_q, sh_d;
        logic             pend_q, pend_d;
        logic             z_q, z_d;
        logic             tc_q, tc_d;
        logic [WIDTH-1:0] sh_new;
        logic             pend_new;
        logic             tc_hit;
        logic             restart;

        // A same-cycle LD is written straight through so any ratio update sees it.
        assign sh_new   = LD[g] ? DIV[g*WIDTH +: WIDTH] : sh_q;
        assign pend_new = LD[g] | pend_q;
        assign tc_hit   = (cnt_q == act_q);
        assign restart  = SYNC | ~EN[g];

        always_comb begin
            cnt_d  = '0;
            act_d  = act_q;
            sh_d   = sh_new;
            pend_d = pend_new;
            z_d    = 1'b0;
            tc_d   = 1'b0;
            if (restart || tc_hit) begin
                if (pend_new) begin
                    act_d  = sh_new;
                    pend_d = 1'b0;
                end
                if (!restart) begin
                    tc_d = 1'b1;
                    z_d  = MODE[g] ? ~z_q : 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                z_d   = MODE[g] & z_q;
            end
        end

        always_ff @(posedge CLK) begin
            if (!RSTN) begin
                cnt_q  <= '0;
                act_q  <= '0;
                sh_q   <= '0;
                pend_q <= 1'b0;
                z_q    <= 1'b0;
                tc_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                sh_q   <= sh_d;
                pend_q <= pend_d;
                z_q    <= z_d;
                tc_q   <= tc_d;
            end
        end

        assign Z[g]  = z_q;
        assign TC[g] = tc_q;

`ifdef GCLKEN_STATUS_EN
        logic ovf_q, ovf_d;

        // Overflow only when the displaced value would otherwise have stayed pending.
        assign ovf_d = ~SYNC & (ovf_q | (LD[g] & pend_q & ~restart & ~tc_hit));

        always_ff @(posedge CLK) begin
            if (!RSTN) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
            end
        end

        assign PEND[g] = pend_q;
        assign OVF[g]  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_gclken_gen.sv
// Directed self-checking bench for gclken_gen (4 channels, 8-bit ratios).
module tb_gclken_gen;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [3:0]  EN;
    logic [3:0]  MODE;
    logic [31:0] DIV;
    logic [3:0]  LD;
    logic        SYNC;
    logic [3:0]  Z;
    logic [3:0]  TC;
`ifdef GCLKEN_STATUS_EN
    logic [3:0]  PEND;
    logic [3:0]  OVF;
`endif

    int checks = 0;
    int errors = 0;

    gclken_gen #(.CHANNELS(4), .WIDTH(8)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .MODE (MODE),
        .DIV  (DIV),
        .LD   (LD),
        .SYNC (SYNC),
        .Z    (Z),
        .TC   (TC)
`ifdef GCLKEN_STATUS_EN
        ,
        .PEND (PEND),
        .OVF  (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Pulse-mode channel: TC and Z high at edge indices first, first+per, ...
    task automatic run_chk(input string tag, input int ch, input int n, input int first, input int per);
        logic e;
        for (int i = 0; i < n; i++) begin
            step();
            e = (i >= first) && (((i - first) % per) == 0);
            check(tag, {31'b0, TC[ch]}, {31'b0, e});
            check(tag, {31'b0, Z[ch]},  {31'b0, e});
        end
    endtask

    initial begin
        logic [3:0] exp_v;
        int acts [3];
        RSTN = 1'b0; EN = '0; MODE = '0; DIV = '0; LD = '0; SYNC = 1'b0;

        // Reset
        step();
        check("rst_z",  {28'b0, Z},  32'h0);
        check("rst_tc", {28'b0, TC}, 32'h0);
`ifdef GCLKEN_STATUS_EN
        check("rst_pend", {28'b0, PEND}, 32'h0);
        check("rst_ovf",  {28'b0, OVF},  32'h0);
`endif
        RSTN = 1'b1;

        // ch0 pulse mode, act=3 loaded while disabled
        LD = 4'b0001; DIV[7:0] = 8'd3;
        step();
        LD = '0; EN = 4'b0001;
        run_chk("s1_div3", 0, 8, 3, 4);
        check("s1_others", {29'b0, Z[3:1]}, 32'h0);

        // Two LDs before TC: last value (5) wins
        LD = 4'b0001; DIV[7:0] = 8'd7;
        step();
        check("s3_ld1_tc", {31'b0, TC[0]}, 32'h0);
        DIV[7:0] = 8'd5;
        step();
        LD = '0;
`ifdef GCLKEN_STATUS_EN
        check("s3_pend", {31'b0, PEND[0]}, 32'h1);
        check("s3_ovf",  {31'b0, OVF[0]},  32'h1);
`endif
        run_chk("s3_div5", 0, 14, 1, 6);

        // LD mid-period: current period finishes, then period 2
        LD = 4'b0001; DIV[7:0] = 8'd1;
        step();
        LD = '0;
        check("s2_ld_tc", {31'b0, TC[0]}, 32'h0);
        run_chk("s2_div1", 0, 9, 4, 2);
`ifdef GCLKEN_STATUS_EN
        check("s2_pend_clr", {31'b0, PEND[0]}, 32'h0);
`endif

        // Toggle mode ch1, act=0 -> CLK/2
        MODE = 4'b0010; EN = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            step();
            check("tog0_z",  {31'b0, Z[1]},  {31'b0, (i % 2) == 0});
            check("tog0_tc", {31'b0, TC[1]}, 32'h1);
        end
        // Toggle mode ch1, act=4 -> 5 high, 5 low
        EN = 4'b0001; LD = 4'b0010; DIV[15:8] = 8'd4;
        step();
        check("tog4_off", {31'b0, Z[1]}, 32'h0);
        LD = '0; EN = 4'b0011;
        for (int i = 0; i < 15; i++) begin
            step();
            check("tog4_z", {31'b0, Z[1]}, {31'b0, (i >= 4) && ((((i - 4) / 5) % 2) == 0)});
        end

        // SYNC with channels at act 2,3,5 and staggered phase
        EN = '0; MODE = '0; LD = 4'b0111;
        DIV[7:0] = 8'd2; DIV[15:8] = 8'd3; DIV[23:16] = 8'd5;
        step();
        LD = '0; EN = 4'b0001;
        step();
        EN = 4'b0011;
        step(); step();
        EN = 4'b0111;
        step();
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        check("sync_z",  {28'b0, Z},  32'h0);
        check("sync_tc", {28'b0, TC}, 32'h0);
`ifdef GCLKEN_STATUS_EN
        check("sync_ovf", {28'b0, OVF}, 32'h0);
`endif
        acts[0] = 2; acts[1] = 3; acts[2] = 5;
        for (int i = 0; i < 7; i++) begin
            step();
            exp_v = '0;
            for (int c = 0; c < 3; c++)
                exp_v[c] = (i >= acts[c]) && (((i - acts[c]) % (acts[c] + 1)) == 0);
            check("sync_run_tc", {28'b0, TC}, {28'b0, exp_v});
            check("sync_run_z",  {28'b0, Z},  {28'b0, exp_v});
        end

        // Reset mid toggle run with a pending shadow
        EN = '0;
        step();
        EN = 4'b0010; MODE = 4'b0010; LD = 4'b0010; DIV[15:8] = 8'd7;
        step();
        LD = '0;
`ifdef GCLKEN_STATUS_EN
        check("rst2_pend_set", {31'b0, PEND[1]}, 32'h1);
`endif
        step();
        RSTN = 1'b0;
        step();
        RSTN = 1'b1;
        check("rst2_z",  {28'b0, Z},  32'h0);
        check("rst2_tc", {28'b0, TC}, 32'h0);
`ifdef GCLKEN_STATUS_EN
        check("rst2_pend", {28'b0, PEND}, 32'h0);
`endif
        MODE = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst2_d0_z",  {28'b0, Z},  32'h2);
            check("rst2_d0_tc", {28'b0, TC}, 32'h2);
        end

        // EN dropped on the terminal-count edge together with LD
        EN = '0; LD = 4'b0001; DIV[7:0] = 8'd3;
        step();
        LD = '0; EN = 4'b0001;
        step(); step(); step();
        EN = '0; LD = 4'b0001; DIV[7:0] = 8'd1;
        step();
        LD = '0;
        check("endrop_z",  {31'b0, Z[0]},  32'h0);
        check("endrop_tc", {31'b0, TC[0]}, 32'h0);
`ifdef GCLKEN_STATUS_EN
        check("endrop_pend", {31'b0, PEND[0]}, 32'h0);
`endif
        EN = 4'b0001;
        run_chk("endrop_div1", 0, 4, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
